// File: rtl/ahb_lite_timer_slave.sv
// AHB-Lite responder exposing a 32-bit auto-reload down-counter timer with a level interrupt.
// Define AHB_TIMER_PRESCALE_EN to add a 16-bit tick prescaler at offset 0x10.
//
// state  | meaning
// IDLE   | ready; accepts address phases, completes zero-wait writes/reads
// RDWAIT | one wait state before read data is presented
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high; may accept the next address phase

module ahb_lite_timer_slave #(
    parameter int          RD_WAIT    = 1,
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        timer_irq
);

    typedef enum logic [1:0] {IDLE, RDWAIT, ERR1, ERR2} state_t;

    localparam bit RD_WAIT_EN = (RD_WAIT != 0);

    state_t      state;
    logic [4:0]  addr_q;
    logic [1:0]  size_q;
    logic        wr_q;

    logic [2:0]  ctrl, ctrl_n;
    logic [31:0] load, load_n;
    logic [31:0] count, count_n;
    logic        expired, expired_n;
    logic [15:0] psc_view;
    logic        tick;

    logic        accept;
    logic        addr_err;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic [31:0] rd_now, rd_q;

    logic        unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:5], HSIZE[2]};

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        case (HSIZE)
            3'b000:  addr_err = 1'b0;
            3'b001:  addr_err = HADDR[0];
            3'b010:  addr_err = (HADDR[1:0] != 2'b00);
            default: addr_err = 1'b1;
        endcase
    end

    // Byte lanes come from the registered data-phase address and size.
    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    assign wr_ctrl   = wr_q & (addr_q[4:2] == 3'd0);
    assign wr_load   = wr_q & (addr_q[4:2] == 3'd1);
    assign wr_count  = wr_q & (addr_q[4:2] == 3'd2);
    assign wr_status = wr_q & (addr_q[4:2] == 3'd3);

`ifdef AHB_TIMER_PRESCALE_EN
    logic [15:0] prescale, prescale_n;
    logic [15:0] psc_cnt, psc_cnt_n;
    logic        wr_psc;

    assign wr_psc = wr_q & (addr_q[4:2] == 3'd4);
    assign tick   = ctrl[0] & (psc_cnt == prescale);

    always_comb begin
        prescale_n = prescale;
        if (wr_psc)
            prescale_n = (prescale & ~wmask[15:0]) | (HWDATA[15:0] & wmask[15:0]);
        if (!ctrl[0] || wr_psc || (psc_cnt == prescale))
            psc_cnt_n = 16'd0;
        else
            psc_cnt_n = psc_cnt + 16'd1;
    end

    assign psc_view = prescale_n;

    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            prescale <= 16'd0;
            psc_cnt  <= 16'd0;
        end else begin
            prescale <= prescale_n;
            psc_cnt  <= psc_cnt_n;
        end
    end
`else
    assign tick     = ctrl[0];
    assign psc_view = 16'd0;
`endif

    // Clear first, then tick, then bus writes: expiry wins over W1C, writes win over the tick.
    always_comb begin
        ctrl_n    = ctrl;
        load_n    = load;
        count_n   = count;
        expired_n = expired;
        if (wr_status && wmask[0] && HWDATA[0])
            expired_n = 1'b0;
        if (tick) begin
            if (count != 32'd0) begin
                count_n = count - 32'd1;
            end else begin
                expired_n = 1'b1;
                if (ctrl[1])
                    count_n = load;
                else
                    ctrl_n[0] = 1'b0;
            end
        end
        if (wr_ctrl)
            ctrl_n = (ctrl & ~wmask[2:0]) | (HWDATA[2:0] & wmask[2:0]);
        if (wr_load)
            load_n = (load & ~wmask) | (HWDATA & wmask);
        if (wr_count)
            count_n = (count & ~wmask) | (HWDATA & wmask);
    end

    function automatic logic [31:0] rd_sel(input logic [2:0]  idx,
                                           input logic [2:0]  c,
                                           input logic [31:0] l,
                                           input logic [31:0] cnt,
                                           input logic        e,
                                           input logic [15:0] p);
        case (idx)
            3'd0:    return {29'd0, c};
            3'd1:    return l;
            3'd2:    return cnt;
            3'd3:    return {31'd0, e};
            3'd4:    return {16'd0, p};
            default: return 32'd0;
        endcase
    endfunction

    // Read data samples post-edge register values, so a write landing this edge is forwarded.
    always_comb begin
        rd_now = rd_sel(HADDR[4:2], ctrl_n, load_n, count_n, expired_n, psc_view);
        rd_q   = rd_sel(addr_q[4:2], ctrl_n, load_n, count_n, expired_n, psc_view);
    end

    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'd0;
            addr_q    <= 5'd0;
            size_q    <= 2'd0;
            wr_q      <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            HRDATA <= 32'd0;
            case (state)
                IDLE, ERR2: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept) begin
                        addr_q <= HADDR[4:0];
                        size_q <= HSIZE[1:0];
                        if (addr_err) begin
                            state     <= ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (!HWRITE && RD_WAIT_EN) begin
                            state     <= RDWAIT;
                            HREADYOUT <= 1'b0;
                        end else if (HWRITE) begin
                            wr_q <= 1'b1;
                        end else begin
                            HRDATA <= rd_now;
                        end
                    end
                end
                RDWAIT: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    HRDATA    <= rd_q;
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            ctrl      <= 3'd0;
            load      <= RESET_LOAD;
            count     <= RESET_LOAD;
            expired   <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            ctrl      <= ctrl_n;
            load      <= load_n;
            count     <= count_n;
            expired   <= expired_n;
            timer_irq <= expired_n & ctrl_n[2];
        end
    end

endmodule

// File: tb/tb_ahb_lite_timer_slave.sv
// Directed bench for ahb_lite_timer_slave (RD_WAIT=1): register table plus timer/pipelining sequences.
module tb_ahb_lite_timer_slave;

    logic        HCLK = 1'b0;
    logic        SI_Reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    ahb_lite_timer_slave #(.RD_WAIT(1), .RESET_LOAD(32'hFFFF_FFFF)) dut (
        .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .timer_irq(timer_irq)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        resp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] wd,
                                logic [31:0] rd, int wt, logic rs);
        vec_t v;
        v.addr = a; v.write = w; v.size = s; v.wdata = wd;
        v.rdata = rd; v.waits = wt; v.resp = rs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; resp_all is 1 only if HRESP was high in every data-phase cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int waits, output logic resp_all);
        bit done;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        waits = 0; resp_all = 1'b1; rdata = 32'd0; done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge HCLK);
            resp_all = resp_all & HRESP;
            if (HREADYOUT) begin
                done  = 1'b1;
                rdata = HRDATA;
            end else begin
                waits++;
                @(posedge HCLK);
            end
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd_unused;
        int w;
        logic r;
        xfer(addr, 1'b1, 3'b010, data, rd_unused, w, r);
        check("wr_resp", {31'd0, r}, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        int w;
        logic r;
        xfer(addr, 1'b0, 3'b010, 32'd0, data, w, r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdat;
        int          w;
        logic        r;

        SI_Reset = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b000; HBURST = 3'b000; HWDATA = 32'd0;

        vecs.push_back(mk(32'h00, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h04, 0, 3'b010, 0, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk(32'h08, 0, 3'b010, 0, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk(32'h0C, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h10, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h1C, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h04, 1, 3'b010, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(32'h05, 1, 3'b000, 32'h0000_AB00, 0, 0, 0));
        vecs.push_back(mk(32'h04, 0, 3'b010, 0, 32'h0000_AB00, 1, 0));
        vecs.push_back(mk(32'h06, 1, 3'b001, 32'h1234_0000, 0, 0, 0));
        vecs.push_back(mk(32'h04, 0, 3'b010, 0, 32'h1234_AB00, 1, 0));
        vecs.push_back(mk(32'h06, 1, 3'b010, 32'hFFFF_FFFF, 0, 1, 1));
        vecs.push_back(mk(32'h04, 1, 3'b011, 32'hFFFF_FFFF, 0, 1, 1));
        vecs.push_back(mk(32'h05, 1, 3'b001, 32'hFFFF_FFFF, 0, 1, 1));
        vecs.push_back(mk(32'h02, 0, 3'b010, 0, 32'h0000_0000, 1, 1));
        vecs.push_back(mk(32'h04, 0, 3'b010, 0, 32'h1234_AB00, 1, 0));
        vecs.push_back(mk(32'h1C, 1, 3'b010, 32'hFFFF_FFFF, 0, 0, 0));
        vecs.push_back(mk(32'h1C, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h01, 1, 3'b000, 32'h0000_FF00, 0, 0, 0));
        vecs.push_back(mk(32'h00, 0, 3'b010, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h08, 1, 3'b001, 32'h0000_1111, 0, 0, 0));
        vecs.push_back(mk(32'h08, 0, 3'b000, 0, 32'hFFFF_1111, 1, 0));
        vecs.push_back(mk(32'h0C, 1, 3'b010, 32'hFFFF_FFFF, 0, 0, 0));
        vecs.push_back(mk(32'h0E, 0, 3'b001, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h07, 1, 3'b000, 32'hFF00_0000, 0, 0, 0));
        vecs.push_back(mk(32'h04, 0, 3'b010, 0, 32'hFF34_AB00, 1, 0));

        repeat (2) @(posedge HCLK);
        #1 SI_Reset = 1'b0;
        @(negedge HCLK);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        @(posedge HCLK); #1;

        foreach (vecs[i]) begin
            xfer(vecs[i].addr, vecs[i].write, vecs[i].size, vecs[i].wdata, rdat, w, r);
            check($sformatf("vec%0d_waits", i), 32'(w), 32'(vecs[i].waits));
            check($sformatf("vec%0d_resp", i), {31'd0, r}, {31'd0, vecs[i].resp});
            if (!vecs[i].write)
                check($sformatf("vec%0d_rdata", i), rdat, vecs[i].rdata);
        end

        // Auto-reload with interrupt: CTRL write lands at edge E, expiry at E+6.
        wr(32'h04, 32'd5);
        wr(32'h08, 32'd5);
        wr(32'h00, 32'h7);
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        check("ar_irq_before", {31'd0, timer_irq}, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("ar_irq_expire", {31'd0, timer_irq}, 32'd1);
        rd(32'h08, rdat);
        check("ar_count_reloaded", rdat, 32'd3);
        check("ar_irq_held", {31'd0, timer_irq}, 32'd1);
        wr(32'h0C, 32'd1);
        check("ar_irq_cleared", {31'd0, timer_irq}, 32'd0);
        wr(32'h00, 32'd0);
        wr(32'h0C, 32'd1);
        rd(32'h0C, rdat);
        check("ar_status_clear", rdat, 32'd0);

        // One-shot; the W1C lands on the expiry edge and loses.
        wr(32'h08, 32'd2);
        wr(32'h00, 32'd1);
        @(posedge HCLK); #1;
        wr(32'h0C, 32'd1);
        rd(32'h00, rdat);
        check("os_en_cleared", rdat, 32'd0);
        rd(32'h0C, rdat);
        check("os_expired_wins", rdat, 32'd1);
        repeat (5) @(posedge HCLK);
        #1;
        rd(32'h08, rdat);
        check("os_count_zero", rdat, 32'd0);
        check("os_irq_masked", {31'd0, timer_irq}, 32'd0);

        // Back-to-back write then read of LOAD.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HWDATA = 32'hDEAD_BEEF; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        check("b2b_wait", {31'd0, HREADYOUT}, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("b2b_ready", {31'd0, HREADYOUT}, 32'd1);
        check("b2b_rdata", HRDATA, 32'hDEAD_BEEF);
        @(posedge HCLK); #1;
        check("idle_rdata_zero", HRDATA, 32'd0);

        // Reset during a write data phase discards the write.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_0055;
        SI_Reset = 1'b1;
        #2 SI_Reset = 1'b0;
        @(posedge HCLK); #1;
        rd(32'h04, rdat);
        check("rst_mid_load", rdat, 32'hFFFF_FFFF);
        rd(32'h00, rdat);
        check("rst_mid_ctrl", rdat, 32'd0);

`ifdef AHB_TIMER_PRESCALE_EN
        wr(32'h10, 32'd3);
        rd(32'h10, rdat);
        check("psc_readback", rdat, 32'd3);
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h5);
        repeat (11) @(posedge HCLK);
        @(negedge HCLK);
        check("psc_irq_before", {31'd0, timer_irq}, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("psc_irq_cycle12", {31'd0, timer_irq}, 32'd1);
        @(posedge HCLK); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_lite_timer_slave.md
Name: ahb_lite_timer_slave

Overview:
- AHB-Lite responder (slave) for the m14k core's AHB-Lite master port.
- Provides a memory-mapped 32-bit down-counter timer with auto-reload and interrupt output.
- Sits behind the system address decoder (which drives HSEL); timer_irq feeds one SI_Int line.
- Implements full AHB-Lite data-phase semantics: wait states, two-cycle ERROR response, little-endian byte lanes.

Parameters:
- RD_WAIT, 1, read data-phase wait states (legal values 0 or 1).
- RESET_LOAD, 32'hFFFF_FFFF, reset value of LOAD and COUNT.

Ports:
- HCLK  in  1  bus/system clock; all state on rising edge.
- SI_Reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  address; only [4:0] decoded.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others are errors.
- HBURST  in  3  ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0 OKAY, 1 ERROR.
- timer_irq  out  1  level interrupt.

Behaviour:
- Register map (HADDR[4:2]):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IE; other bits read 0.
  - 0x04 LOAD.
  - 0x08 COUNT: read returns live value; write loads the count.
  - 0x0C STATUS: [0] EXPIRED; writing 1 clears it.
  - 0x10–0x1C: read 0, writes ignored (see Optional Feature).
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, timer_irq=0.
  - CTRL=0, STATUS=0, LOAD=COUNT=RESET_LOAD.
  - FSM returns to IDLE.
  - Reset mid-transfer aborts it; no register update occurs.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. Address[4:0], HWRITE and HSIZE are registered.
- Error check at acceptance. A transfer errors if:
  - HSIZE > 3'b010, or
  - half-word with HADDR[0]=1, or
  - word with HADDR[1:0]≠0.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted error → ERR1.
    - Accepted read with RD_WAIT=1 → RDWAIT.
    - Otherwise stays in IDLE; a write completes with zero waits and its register update lands at the data-phase clock edge using HWDATA.
  - RDWAIT: HREADYOUT=0, HRESP=0; → IDLE next cycle. HRDATA is valid when HREADYOUT returns to 1.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 → IDLE. No register is modified by an errored transfer.
- Read data:
  - Registered from the decoded register, with all 32 bits driven regardless of HSIZE.
  - With RD_WAIT=0, the read data-phase completes in one cycle.
  - HRDATA is 0 for an idle or unselected data phase.
- Writes:
  - Little-endian byte lanes.
  - A byte write to offset b updates bits [8b+7:8b] only.
  - A half-word write updates the selected 16-bit half.
- Back-to-back transfers: a new address phase may be accepted in the same cycle HREADYOUT=1 ends the previous data phase. The write at data phase N and the read at address phase N+1 to the same register return the new value.
- Timer operation (each tick while EN=1):
  - If COUNT≠0: COUNT←COUNT−1.
  - If COUNT==0: EXPIRED←1. If AUTO_RELOAD, COUNT←LOAD; else EN←0 and COUNT stays 0.
- Simultaneous events:
  - A bus write to COUNT or CTRL beats a tick update in the same cycle.
  - Expiry beats a W1C clear of EXPIRED in the same cycle.
- timer_irq = EXPIRED & IE, driven from flops.

Optional Feature:
- Macro AHB_TIMER_PRESCALE_EN.
- Defined:
  - 0x10 becomes PRESCALE[15:0], read/write, reset 0.
  - An internal 16-bit prescale counter generates a tick when it equals PRESCALE, then wraps to 0.
  - The prescale counter clears whenever EN=0 or PRESCALE is written.
  - PRESCALE=0 gives a tick every cycle.
- Not defined: tick every cycle while EN=1; 0x10 reads 0 and writes are ignored.

Test Plan:
- Reset then read all regs (RD_WAIT=1) → one wait cycle per read; CTRL=0, LOAD=COUNT=FFFF_FFFF, STATUS=0, timer_irq=0.
- Write LOAD=5, COUNT=5, CTRL=3'b111; wait 6 cycles → EXPIRED=1, timer_irq=1, COUNT reloads to 5; write STATUS=1 → irq clears on the next edge.
- CTRL=3'b001, COUNT=2 → after 3 ticks COUNT=0, EN reads 0, EXPIRED=1; further cycles leave COUNT=0.
- Word write to 0x06 or HSIZE=3'b011 → HREADYOUT 0 then 1 with HRESP=1 both cycles; LOAD unchanged.
- Byte write 0xAB to 0x05 after LOAD=0 → LOAD reads 0x0000_AB00; back-to-back write LOAD / read LOAD returns the new value.
- With AHB_TIMER_PRESCALE_EN, PRESCALE=3, COUNT=2, EN=1 → COUNT decrements every 4 cycles; expiry at cycle 12.
